// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, SIZE codes and the
// request legality rule used at accept time.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  function automatic logic is_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_B, SZ_BU: ok = 1'b1;
      SZ_H, SZ_HU: ok = ~addr_lo[0];
      SZ_W:        ok = (addr_lo == 2'b00);
      default:     ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_word(input logic [2:0] size);
    return (size == SZ_W);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte/half lane handling: extracts and extends the addressed lane of a
// memory word for loads, and merges sub-word store data into that word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ext_rdata_o,
  output logic [31:0] merged_wd_o
);

  logic [4:0]  bit_ofs;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign bit_ofs = {addr_lo_i, 3'b000};

  always_comb begin
    byte_sel = word_i[bit_ofs +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

    case (size_i)
      SZ_B:    ext_rdata_o = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   ext_rdata_o = {24'h000000, byte_sel};
      SZ_H:    ext_rdata_o = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   ext_rdata_o = {16'h0000, half_sel};
      SZ_W:    ext_rdata_o = word_i;
      default: ext_rdata_o = 32'h0;
    endcase
  end

  always_comb begin
    merged_wd_o = word_i;
    case (size_i)
      SZ_B, SZ_BU: merged_wd_o[bit_ofs +: 8] = wdata_i[7:0];
      SZ_H, SZ_HU: begin
        if (addr_lo_i[1]) merged_wd_o[31:16] = wdata_i[15:0];
        else              merged_wd_o[15:0]  = wdata_i[15:0];
      end
      default:     merged_wd_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit sequencing single-port data-RAM accesses, with
// read-modify-write for sub-word stores.
//   state      | meaning
//   ST_IDLE    | waiting for req_i; latches request on accept
//   ST_ACCESS  | address on RAM; word store writes here
//   ST_CAPTURE | RAM read data valid; extend (load) or merge (sub-word store)
//   ST_WRITE   | merged word written back
//   ST_RESP    | done_o pulse, err_o/rdata_o valid
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              m_we_o,
  output logic [ADDR_W-1:0] m_a_o,
  output logic [31:0]       m_wd_o,
  input  logic [31:0]       m_rd_i
);

  state_e            state_q;
  logic              we_q;
  logic [2:0]        size_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       rdata_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_a_q;
  logic [31:0]       m_wd_q;

  logic [31:0]       ext_rdata;
  logic [31:0]       merged_wd;

  lsu_lane u_lane (
    .word_i      (m_rd_i),
    .addr_lo_i   (addr_lo_q),
    .size_i      (size_q),
    .wdata_i     (wdata_q),
    .ext_rdata_o (ext_rdata),
    .merged_wd_o (merged_wd)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= 3'b000;
      addr_lo_q <= 2'b00;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= 32'h0;
      m_we_q    <= 1'b0;
      m_a_q     <= '0;
      m_wd_q    <= 32'h0;
    end else begin
      // Strobes default low so each can only last the one cycle that sets it.
      done_q <= 1'b0;
      m_we_q <= 1'b0;
      m_wd_q <= 32'h0;

      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            we_q      <= we_i;
            size_q    <= size_i;
            addr_lo_q <= addr_i[1:0];
            wdata_q   <= wdata_i;
            m_a_q     <= {addr_i[ADDR_W-1:2], 2'b00};
            busy_q    <= 1'b1;
            if (!is_legal(size_i, addr_i[1:0])) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              rdata_q <= 32'h0;
              state_q <= ST_RESP;
            end else begin
              err_q   <= 1'b0;
              state_q <= ST_ACCESS;
              if (we_i && is_word(size_i)) begin
                m_we_q <= 1'b1;
                m_wd_q <= wdata_i;
              end
            end
          end
        end

        ST_ACCESS: begin
          if (we_q && is_word(size_q)) begin
            done_q  <= 1'b1;
            rdata_q <= 32'h0;
            state_q <= ST_RESP;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          if (we_q) begin
            m_we_q  <= 1'b1;
            m_wd_q  <= merged_wd;
            state_q <= ST_WRITE;
          end else begin
            rdata_q <= ext_rdata;
            done_q  <= 1'b1;
            state_q <= ST_RESP;
          end
        end

        ST_WRITE: begin
          rdata_q <= 32'h0;
          done_q  <= 1'b1;
          state_q <= ST_RESP;
        end

        ST_RESP: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata_o = rdata_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign m_we_o  = m_we_q;
  assign m_a_o   = m_a_q;
  assign m_wd_o  = m_wd_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a word-array memory model with
// arithmetic lane rules; checks latency, ERR, RDATA and every RAM write.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        we_i;
  logic [2:0]  size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        m_we_o;
  logic [31:0] m_a_o;
  logic [31:0] m_wd_o;
  logic [31:0] m_rd_i;

  always #5 clk_i = ~clk_i;

  lsu #(.ADDR_W(32)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .we_i    (we_i),
    .size_i  (size_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .m_we_o  (m_we_o),
    .m_a_o   (m_a_o),
    .m_wd_o  (m_wd_o),
    .m_rd_i  (m_rd_i)
  );

  // Synchronous data RAM: 64 words, read data one cycle after the address.
  logic [31:0] ram [64];
  always @(posedge clk_i) begin
    if (m_we_o) ram[m_a_o[7:2]] <= m_wd_o;
    m_rd_i <= ram[m_a_o[7:2]];
  end

  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [31:0] wr_addr  = 32'h0;
  logic [31:0] wr_data  = 32'h0;
  always @(posedge clk_i) begin
    if (m_we_o) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= m_a_o;
      wr_data <= m_wd_o;
    end
    if (done_o) done_cnt <= done_cnt + 1;
  end

  logic [31:0] mdl [64];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_legal(input bit [2:0] s, input bit [31:0] a);
    case (s)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input bit [31:0] a, input bit [2:0] s);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (s)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input bit [31:0] a,
                                            input bit [2:0] s, input logic [31:0] d);
    logic [31:0] mask;
    int          sh;
    case (s)
      3'd0, 3'd4: begin
        sh   = 8 * (a % 4);
        mask = 32'hFF << sh;
        return (w & ~mask) | ((d & 32'hFF) << sh);
      end
      3'd1, 3'd5: begin
        sh   = 16 * ((a % 4) / 2);
        mask = 32'hFFFF << sh;
        return (w & ~mask) | ((d & 32'hFFFF) << sh);
      end
      default: return d;
    endcase
  endfunction

  task automatic run_req(input bit we, input bit [2:0] sz, input bit [31:0] a,
                         input logic [31:0] d, input string tag);
    bit          legal;
    int          exp_lat, lat, w0, idx;
    logic [31:0] exp_wd;
    legal   = ref_legal(sz, a);
    exp_lat = !legal ? 1 : (we && sz == 3'd2) ? 2 : !we ? 3 : 4;
    idx     = int'(a[7:2]);
    @(negedge clk_i);
    w0      = wr_cnt;
    req_i   = 1'b1;
    we_i    = we;
    size_i  = sz;
    addr_i  = a;
    wdata_i = d;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        lat = k;
        break;
      end
    end
    last_rdata = rdata_o;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " err"}, {31'b0, err_o}, {31'b0, !legal});
    chk({tag, " m_we idle"}, {31'b0, m_we_o}, 32'h0);
    chk({tag, " m_wd idle"}, m_wd_o, 32'h0);
    if (!we || !legal)
      chk({tag, " rdata"}, rdata_o, legal ? ref_load(mdl[idx], a, sz) : 32'h0);
    chk({tag, " writes"}, wr_cnt - w0, (legal && we) ? 1 : 0);
    if (legal && we) begin
      exp_wd = ref_store(mdl[idx], a, sz, d);
      chk({tag, " wr addr"}, wr_addr, {a[31:2], 2'b00});
      chk({tag, " wr data"}, wr_data, exp_wd);
      mdl[idx] = exp_wd;
    end
    @(negedge clk_i);
    chk({tag, " done pulse"}, {31'b0, done_o}, 32'h0);
    chk({tag, " busy end"}, {31'b0, busy_o}, 32'h0);
  endtask

  initial begin
    int          w0, d0;
    logic [31:0] dat;
    bit   [2:0]  sz;
    bit   [31:0] a;
    rst_ni  = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    size_i  = 3'b000;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
    repeat (3) @(negedge clk_i);
    chk("rst busy", {31'b0, busy_o}, 32'h0);
    chk("rst done", {31'b0, done_o}, 32'h0);
    chk("rst err", {31'b0, err_o}, 32'h0);
    chk("rst m_we", {31'b0, m_we_o}, 32'h0);
    chk("rst m_a", m_a_o, 32'h0);
    chk("rst m_wd", m_wd_o, 32'h0);
    chk("rst rdata", rdata_o, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Fill every word then read it back.
    for (int i = 0; i < 64; i++) begin
      dat = $urandom;
      run_req(1'b1, 3'd2, 32'(i * 4), dat, "fill sw");
      run_req(1'b0, 3'd2, 32'(i * 4), 32'h0, "fill lw");
      chk("fill lw value", last_rdata, dat);
    end

    run_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw 0x10");
    chk("sw 0x10 data", wr_data, 32'hDEADBEEF);
    run_req(1'b0, 3'd0, 32'h13, 32'h0, "lb 0x13");
    chk("lb 0x13 value", last_rdata, 32'hFFFFFFDE);
    run_req(1'b0, 3'd4, 32'h13, 32'h0, "lbu 0x13");
    chk("lbu 0x13 value", last_rdata, 32'h000000DE);
    run_req(1'b0, 3'd1, 32'h12, 32'h0, "lh 0x12");
    chk("lh 0x12 value", last_rdata, 32'hFFFFDEAD);

    run_req(1'b1, 3'd2, 32'h20, 32'h11223344, "sw 0x20");
    run_req(1'b1, 3'd0, 32'h21, 32'h000000AA, "sb 0x21");
    chk("sb 0x21 word", wr_data, 32'h1122AA44);
    run_req(1'b1, 3'd1, 32'h22, 32'h0000BEEF, "sh 0x22");
    chk("sh 0x22 word", wr_data, 32'hBEEFAA44);

    run_req(1'b0, 3'd2, 32'h06, 32'h0, "lw 0x06");
    run_req(1'b1, 3'd1, 32'h05, 32'h1234, "sh 0x05");
    run_req(1'b0, 3'd3, 32'h10, 32'h0, "size 011");

    // Extra request held while busy must be dropped.
    @(negedge clk_i);
    w0 = wr_cnt; d0 = done_cnt;
    req_i = 1'b1; we_i = 1'b1; size_i = 3'd0; addr_i = 32'h41; wdata_i = 32'h55;
    @(posedge clk_i);
    #1 size_i = 3'd2; addr_i = 32'h80; wdata_i = 32'h12345678;
    repeat (2) @(negedge clk_i);
    req_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("busy ign dones", done_cnt - d0, 1);
    chk("busy ign writes", wr_cnt - w0, 1);
    chk("busy ign addr", wr_addr, 32'h40);
    chk("busy ign data", wr_data, ref_store(mdl[16], 32'h41, 3'd0, 32'h55));
    mdl[16] = ref_store(mdl[16], 32'h41, 3'd0, 32'h55);
    run_req(1'b0, 3'd2, 32'h80, 32'h0, "busy ign lw 0x80");

    // Reset while an sb sits in CAPTURE.
    @(negedge clk_i);
    w0 = wr_cnt; d0 = done_cnt;
    req_i = 1'b1; we_i = 1'b1; size_i = 3'd0; addr_i = 32'h61; wdata_i = 32'h77;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy_o}, 32'h0);
    chk("abort m_we", {31'b0, m_we_o}, 32'h0);
    chk("abort m_a", m_a_o, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk_i);
    chk("abort writes", wr_cnt - w0, 0);
    chk("abort dones", done_cnt - d0, 0);
    run_req(1'b0, 3'd4, 32'h61, 32'h0, "after abort lbu");

    for (int i = 0; i < 200; i++) begin
      sz  = 3'($urandom_range(0, 7));
      a   = 32'($urandom_range(0, 255));
      dat = $urandom;
      run_req(1'($urandom_range(0, 1)), sz, a, dat, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of ADDR and M_A; data width is fixed at 32.
REQ-002 CLK  in  1  single clock; all state changes on posedge CLK.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 REQ  in  1  core request strobe; sampled only in IDLE.
REQ-005 WE  in  1  1 = store, 0 = load.
REQ-006 SIZE  in  3  000 sb/lb, 001 sh/lh, 010 sw/lw, 100 lbu, 101 lhu; all other codes are illegal.
REQ-007 ADDR  in  ADDR_W  byte address.
REQ-008 WDATA  in  32  store data, right-aligned.
REQ-009 RDATA  out  32  load result, extended; valid only while DONE=1.
REQ-010 BUSY  out  1  1 when state is not IDLE.
REQ-011 DONE  out  1  one-cycle completion pulse.
REQ-012 ERR  out  1  qualifies DONE; 1 = misaligned or illegal request.
REQ-013 M_WE  out  1  data-RAM write enable.
REQ-014 M_A  out  ADDR_W  data-RAM address, always word-aligned ({ADDR[ADDR_W-1:2],2'b00}).
REQ-015 M_WD  out  32  data-RAM write data.
REQ-016 M_RD  in  32  data-RAM read data; valid in the cycle after M_A is driven with M_WE=0.

Function
REQ-017 The FSM SHALL use the states IDLE, ACCESS, CAPTURE, WRITE and RESP.
REQ-018 IDLE, REQ=1: latch WE/SIZE/ADDR/WDATA; go to RESP with err flag set if the request is illegal (REQ-019), else go to ACCESS.
REQ-019 Illegal: SIZE not in the REQ-006 list, or halfword with ADDR[0]=1, or word with ADDR[1:0]!=0; no memory access occurs (M_WE stays 0).
REQ-020 ACCESS: drive M_A; store word -> M_WE=1, M_WD=WDATA, then RESP; load or sub-word store -> M_WE=0, then CAPTURE.
REQ-021 CAPTURE: register M_RD; load -> RESP; sub-word store -> WRITE.
REQ-022 WRITE: M_WE=1; M_WD = captured word with only the addressed byte lane (ADDR[1:0]) or half lane (ADDR[1]) replaced by WDATA[7:0]/WDATA[15:0]; then RESP.
REQ-023 RESP: DONE=1 for exactly one cycle; ERR per the latched flag; RDATA = lane-selected value, sign-extended for 000/001, zero-extended for 100/101, full word for 010, 0 on ERR; then IDLE.
REQ-024 Latency from the REQ-sampling edge to DONE: sw 2 cycles, load 3, sb/sh 4, illegal 1.
REQ-025 REQ while BUSY SHALL be ignored (not queued); REQ in IDLE is accepted on the same edge, so back-to-back requests are allowed one cycle after DONE.
REQ-026 M_WE SHALL be 1 only in ACCESS (store word) or WRITE; it SHALL never be 1 for more than one cycle per request.
REQ-027 Outside ACCESS/WRITE, M_A SHALL hold the latched aligned address and M_WD SHALL be 0.

Reset
REQ-028 RST_N=0 SHALL immediately force state IDLE, with M_WE, DONE, ERR and BUSY at 0 and RDATA, M_A, M_WD and all latches at 0.
REQ-029 Reset asserted mid-operation SHALL abort the request with no DONE and no subsequent partial write; on release the block accepts a fresh REQ.

Structure
REQ-030 Package lsu_pkg SHALL hold the state enum, the SIZE encoding constants and an is_legal function.
REQ-031 Lane select/extend and lane merge SHALL be the combinational sub-module lsu_lane (inputs word, ADDR[1:0], SIZE, WDATA; outputs ext_rdata, merged_wd).

Verification
REQ-032 sw ADDR=0x10, WDATA=0xDEADBEEF -> M_WE=1 for one cycle with M_A=0x10 and M_WD=0xDEADBEEF; DONE 2 cycles after accept, ERR=0.
REQ-033 RAM[0x10]=0xDEADBEEF; lb at 0x13 -> RDATA=0xFFFFFFDE; lbu at 0x13 -> 0x000000DE; lh at 0x12 -> 0xFFFFDEAD; DONE 3 cycles after accept.
REQ-034 RAM[0x20]=0x11223344; sb ADDR=0x21, WDATA=0xAA -> one write of 0x1122AA44; sh ADDR=0x22, WDATA=0xBEEF -> 0xBEEFAA44.
REQ-035 lw at 0x06, sh at 0x05 and SIZE=011 -> DONE and ERR next cycle, RDATA=0, M_WE never asserted.
REQ-036 Second REQ pulsed while BUSY -> ignored, exactly one DONE; RST_N dropped during CAPTURE of an sb -> no write, BUSY=0 immediately.
REQ-037 Loop over all 64 word addresses 0x00..0xFC: sw random data then lw -> RDATA matches; self-checking Good/Bad report per access.
